// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle shared by the arbiter and its neighbours.
interface sram_arbiter_if #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 8
);
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              clr_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wrapped;
   logic              busy;
   logic              sram_cen;
   logic              sram_oen;
   logic              sram_wen;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dout;
   logic              sram_dout_en;
   logic [DATA_W-1:0] sram_din;

   modport slave (
      input  wr_req, wr_data, rd_req, rd_addr, clr_ptr, sram_din,
      output wr_ack, rd_data, rd_valid, wr_ptr, wrapped, busy,
             sram_cen, sram_oen, sram_wen, sram_addr, sram_dout, sram_dout_en
   );

   modport master (
      output wr_req, wr_data, rd_req, rd_addr, clr_ptr, sram_din,
      input  wr_ack, rd_data, rd_valid, wr_ptr, wrapped, busy,
             sram_cen, sram_oen, sram_wen, sram_addr, sram_dout, sram_dout_en
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sequencing log writes and SPI reads onto one async SRAM
// as setup / strobe / hold phases, with every pin driven straight from a flop.
module sram_arbiter #(
   parameter int unsigned ADDR_W        = 17,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;
   typedef enum logic {G_READ, G_WRITE} grant_e;

   state_e            state_q, state_d;
   grant_e            grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cen_q, cen_d;
   logic              oen_q, oen_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_en_q, dout_en_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              wrapped_q, wrapped_d;
   logic              busy_q, busy_d;
   logic              grant_wr;

   // Write wins when alone or when the read went last.
   assign grant_wr = bus.wr_req && (!bus.rd_req || (grant_q == G_READ));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      cen_d      = cen_q;
      oen_d      = oen_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      dout_en_d  = dout_en_q;
      wr_ack_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      wr_ptr_d   = wr_ptr_q;
      wrapped_d  = wrapped_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.wr_req || bus.rd_req) begin
               state_d = S_SETUP;
               cen_d   = 1'b0;
               if (grant_wr) begin
                  grant_d   = G_WRITE;
                  addr_d    = wr_ptr_q;
                  dout_d    = bus.wr_data;
                  dout_en_d = 1'b1;
               end else begin
                  grant_d = G_READ;
                  addr_d  = bus.rd_addr;
               end
            end
         end
         S_SETUP: begin
            state_d = S_STROBE;
            cnt_d   = '0;
            wen_d   = (grant_q != G_WRITE);
            oen_d   = (grant_q == G_WRITE);
         end
         S_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_HOLD;
               wen_d   = 1'b1;
               oen_d   = 1'b1;
               if (grant_q == G_WRITE) begin
                  wr_ack_d = 1'b1;
               end else begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.sram_din;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            state_d   = S_IDLE;
            cen_d     = 1'b1;
            dout_en_d = 1'b0;
            if (grant_q == G_WRITE) begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (wr_ptr_q == '1) begin
                  wrapped_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Clear overrides a coincident increment; the in-flight address is already latched.
      if (bus.clr_ptr) begin
         wr_ptr_d  = '0;
         wrapped_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= G_READ;
         cnt_q      <= '0;
         cen_q      <= 1'b1;
         oen_q      <= 1'b1;
         wen_q      <= 1'b1;
         addr_q     <= '0;
         dout_q     <= '0;
         dout_en_q  <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         wr_ptr_q   <= '0;
         wrapped_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         cen_q      <= cen_d;
         oen_q      <= oen_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         dout_en_q  <= dout_en_d;
         wr_ack_q   <= wr_ack_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         wr_ptr_q   <= wr_ptr_d;
         wrapped_q  <= wrapped_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.sram_cen     = cen_q;
   assign bus.sram_oen     = oen_q;
   assign bus.sram_wen     = wen_q;
   assign bus.sram_addr    = addr_q;
   assign bus.sram_dout    = dout_q;
   assign bus.sram_dout_en = dout_en_q;
   assign bus.wr_ack       = wr_ack_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.wr_ptr       = wr_ptr_q;
   assign bus.wrapped      = wrapped_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: SRAM model, per-cycle pin monitor, and a
// 4-bit-address instance for pointer wrap.
module tb_sram_arbiter;

   logic clk;
   logic rst;

   sram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();
   sram_arbiter_if #(.ADDR_W(4),  .DATA_W(8)) bus2 ();

   sram_arbiter #(.ADDR_W(17), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   sram_arbiter #(.ADDR_W(4), .DATA_W(8), .ACCESS_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t        wr_q[$];
   exp_t        rd_q[$];
   bit          grant_q[$];
   logic [7:0]  sram_mem [0:131071];
   logic [7:0]  ref_mem  [0:131071];
   logic [16:0] exp_ptr;
   int          n_checks;
   int          n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Async SRAM model behind the pads.
   always @(posedge clk)
      if (!bus.sram_cen && !bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_dout;
   assign bus.sram_din  = (!bus.sram_cen && !bus.sram_oen) ? sram_mem[bus.sram_addr] : 8'h00;
   assign bus2.sram_din = 8'h00;

   logic [16:0] cap_waddr, cap_raddr;
   logic [7:0]  cap_wdata;
   int          wen_cnt, oen_cnt;
   logic        prev_cen;

   // Pin monitor: strobe widths, bus contention, grant order and scoreboard pops.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         wen_cnt  = 0;
         oen_cnt  = 0;
         prev_cen = 1'b1;
      end else begin
         if (!bus.sram_wen) begin
            wen_cnt++;
            cap_waddr = bus.sram_addr;
            cap_wdata = bus.sram_dout;
            check("wen_dout_en", 32'(bus.sram_dout_en), 1);
            check("wen_oen_overlap", 32'(bus.sram_oen), 1);
         end else if (wen_cnt != 0) begin
            check("wen_width", wen_cnt, 2);
            wen_cnt = 0;
         end
         if (!bus.sram_oen) begin
            oen_cnt++;
            cap_raddr = bus.sram_addr;
            check("oen_dout_en", 32'(bus.sram_dout_en), 0);
         end else if (oen_cnt != 0) begin
            check("oen_width", oen_cnt, 2);
            oen_cnt = 0;
         end
         if (!bus.sram_cen && prev_cen && grant_q.size() > 0) begin
            bit g;
            g = grant_q.pop_front();
            check("grant_order", 32'(bus.sram_dout_en), 32'(g));
         end
         prev_cen = bus.sram_cen;
         if (bus.wr_ack) begin
            if (wr_q.size() == 0) check("wr_ack_spurious", 32'(bus.wr_ack), 0);
            else begin
               exp_t e;
               e = wr_q.pop_front();
               check("wr_addr", 32'(cap_waddr), 32'(e.addr));
               check("wr_data", 32'(cap_wdata), 32'(e.data));
            end
         end
         if (bus.rd_valid) begin
            if (rd_q.size() == 0) check("rd_valid_spurious", 32'(bus.rd_valid), 0);
            else begin
               exp_t e;
               e = rd_q.pop_front();
               check("rd_addr", 32'(cap_raddr), 32'(e.addr));
               check("rd_data", 32'(bus.rd_data), 32'(e.data));
            end
         end
      end
   end

   task automatic do_write(input logic [7:0] d, input bit chk_lat, input bit do_clr, input bit keep);
      exp_t e;
      int   cyc;
      bit   got;
      if (!bus.wr_req) begin
         @(posedge clk); #1;
      end
      bus.wr_data = d;
      bus.wr_req  = 1'b1;
      e.addr = exp_ptr;
      e.data = d;
      wr_q.push_back(e);
      ref_mem[exp_ptr] = d;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         if (bus.wr_ack) got = 1'b1;
         else cyc++;
      end
      check("wr_ack_seen", 32'(got), 1);
      if (chk_lat) check("wr_latency", cyc, 4);
      check("busy_in_hold", 32'(bus.busy), 1);
      if (do_clr) bus.clr_ptr = 1'b1;
      @(posedge clk); #1;
      if (!keep) bus.wr_req = 1'b0;
      bus.clr_ptr = 1'b0;
      exp_ptr = do_clr ? 17'd0 : exp_ptr + 17'd1;
      check("wr_ptr", 32'(bus.wr_ptr), 32'(exp_ptr));
      if (do_clr) check("wrapped_clr", 32'(bus.wrapped), 0);
   endtask

   task automatic do_read(input logic [16:0] a, input bit chk_lat, input bit keep);
      exp_t e;
      int   cyc;
      bit   got;
      if (!bus.rd_req) begin
         @(posedge clk); #1;
      end
      bus.rd_addr = a;
      bus.rd_req  = 1'b1;
      e.addr = a;
      e.data = ref_mem[a];
      rd_q.push_back(e);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         if (bus.rd_valid) got = 1'b1;
         else cyc++;
      end
      check("rd_valid_seen", 32'(got), 1);
      if (chk_lat) check("rd_latency", cyc, 4);
      @(posedge clk); #1;
      if (!keep) bus.rd_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_ptr = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      bit any_ack;
      bit got;
      int cyc;
      n_checks = 0;
      n_pass   = 0;
      exp_ptr  = '0;
      rst = 1'b1;
      {bus.wr_req, bus.rd_req, bus.clr_ptr} = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      {bus2.wr_req, bus2.rd_req, bus2.clr_ptr} = '0;
      bus2.wr_data = '0;
      bus2.rd_addr = '0;
      sram_mem[17'h10] = 8'h3C; ref_mem[17'h10] = 8'h3C;
      sram_mem[17'h20] = 8'h77; ref_mem[17'h20] = 8'h77;
      sram_mem[17'h30] = 8'hC1; ref_mem[17'h30] = 8'hC1;

      #12;
      check("rst_cen", 32'(bus.sram_cen), 1);
      check("rst_oen", 32'(bus.sram_oen), 1);
      check("rst_wen", 32'(bus.sram_wen), 1);
      check("rst_dout_en", 32'(bus.sram_dout_en), 0);
      check("rst_addr", 32'(bus.sram_addr), 0);
      check("rst_dout", 32'(bus.sram_dout), 0);
      check("rst_rd_data", 32'(bus.rd_data), 0);
      check("rst_wr_ptr", 32'(bus.wr_ptr), 0);
      check("rst_wr_ack", 32'(bus.wr_ack), 0);
      check("rst_rd_valid", 32'(bus.rd_valid), 0);
      check("rst_wrapped", 32'(bus.wrapped), 0);
      check("rst_busy", 32'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;

      do_write(8'hA5, 1'b1, 1'b0, 1'b0);
      do_read(17'h10, 1'b1, 1'b0);
      check("rd_data_hold", 32'(bus.rd_data), 32'h3C);

      // Both requesters held high: round-robin must alternate starting with the write.
      do_reset();
      repeat (3) begin
         grant_q.push_back(1'b1);
         grant_q.push_back(1'b0);
      end
      fork
         begin
            do_write(8'h01, 1'b0, 1'b0, 1'b1);
            do_write(8'h02, 1'b0, 1'b0, 1'b1);
            do_write(8'h03, 1'b0, 1'b0, 1'b0);
         end
         begin
            do_read(17'h10, 1'b0, 1'b1);
            do_read(17'h20, 1'b0, 1'b1);
            do_read(17'h30, 1'b0, 1'b0);
         end
      join
      check("grant_q_drained", grant_q.size(), 0);

      do_write(8'h44, 1'b0, 1'b0, 1'b0);
      do_write(8'h55, 1'b0, 1'b0, 1'b0);
      check("ptr_before_clr", 32'(bus.wr_ptr), 5);
      do_write(8'h66, 1'b1, 1'b1, 1'b0);

      // Abort a write mid-strobe with reset.
      do_write(8'h22, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.wr_data = 8'h5A;
      bus.wr_req  = 1'b1;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         if (!bus.sram_wen) got = 1'b1;
         else cyc++;
      end
      check("abort_strobe_seen", 32'(got), 1);
      #1 rst = 1'b1;
      bus.wr_req = 1'b0;
      #1;
      check("abort_wen", 32'(bus.sram_wen), 1);
      check("abort_cen", 32'(bus.sram_cen), 1);
      check("abort_oen", 32'(bus.sram_oen), 1);
      check("abort_dout_en", 32'(bus.sram_dout_en), 0);
      check("abort_wr_ptr", 32'(bus.wr_ptr), 0);
      exp_ptr = '0;
      @(posedge clk); #2 rst = 1'b0;
      any_ack = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any_ack = any_ack | bus.wr_ack;
      end
      check("abort_no_ack", 32'(any_ack), 0);
      do_write(8'h33, 1'b1, 1'b0, 1'b0);

      // Pointer wrap on the 4-bit instance.
      @(posedge clk); #1;
      bus2.wr_req = 1'b1;
      for (int i = 0; i < 17; i++) begin
         bus2.wr_data = 8'(i);
         got = 1'b0;
         cyc = 0;
         while (!got && cyc < 20) begin
            @(negedge clk);
            if (!bus2.sram_wen) got = 1'b1;
            else cyc++;
         end
         check("wrap_strobe_seen", 32'(got), 1);
         check("wrap_addr", 32'(bus2.sram_addr), 32'(i % 16));
         got = 1'b0;
         cyc = 0;
         while (!got && cyc < 20) begin
            @(negedge clk);
            if (bus2.wr_ack) got = 1'b1;
            else cyc++;
         end
         check("wrap_ack_seen", 32'(got), 1);
         @(posedge clk); #1;
         if (i == 16) bus2.wr_req = 1'b0;
         if (i == 14) check("wrap_not_yet", 32'(bus2.wrapped), 0);
         if (i == 15) begin
            check("wrap_ptr_zero", 32'(bus2.wr_ptr), 0);
            check("wrap_sticky", 32'(bus2.wrapped), 1);
         end
         if (i == 16) begin
            check("wrap_ptr_after", 32'(bus2.wr_ptr), 1);
            check("wrap_still_set", 32'(bus2.wrapped), 1);
         end
      end

      repeat (4) @(posedge clk);
      check("wr_q_empty", wr_q.size(), 0);
      check("rd_q_empty", rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
